inv_sub_bytes_seq: RTL and testbench

Iterative AES InvSubBytes engine for the decryption datapath: it accepts one 128-bit state over a valid/ready handshake and applies the AES inverse S-box to all 16 bytes. It uses BYTES_PER_CYCLE inverse S-box lanes, so one block takes 16/BYTES_PER_CYCLE cycles. It is the decrypt-side counterpart of the forward `sbox` lookup and sits between the InvShiftRows and AddRoundKey stages of the round controller.

---
 rtl/inv_sub_bytes_seq.sv | 146 ++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: one 128-bit state per handshake,
// BYTES_PER_CYCLE inverse S-box lanes applied while rotating the state register.

module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // FIPS-197 inverse S-box
    always_comb begin
        case (a)
            8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5; 8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
            8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e; 8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
            8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82; 8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
            8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44; 8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
            8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32; 8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
            8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b; 8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
            8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66; 8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
            8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49; 8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
            8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64; 8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
            8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc; 8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
            8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50; 8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
            8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57; 8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
            8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00; 8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
            8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05; 8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
            8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f; 8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
            8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03; 8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
            8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41; 8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
            8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce; 8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
            8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22; 8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
            8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8; 8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
            8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71; 8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
            8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e; 8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
            8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b; 8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
            8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe; 8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
            8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33; 8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
            8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59; 8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
            8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9; 8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
            8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f; 8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
            8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d; 8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
            8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c; 8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
            8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e; 8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
            8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63; 8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
            default: y = 8'h00;
        endcase
    end
endmodule

module inv_sub_bytes_seq #(
    parameter int unsigned BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int unsigned N  = 16 / BYTES_PER_CYCLE;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SW = 8 * BYTES_PER_CYCLE;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
        $error("inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t          state;
    state_t          state_next;
    logic [127:0]    sr;
    logic [127:0]    sr_rot;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   sub;
    logic            last;

    // Lane l substitutes the l-th byte from the top; results keep their order
    for (genvar l = 0; l < int'(BYTES_PER_CYCLE); l++) begin : g_lane
        inv_sbox u_inv_sbox (
            .a (sr[127 - 8*l -: 8]),
            .y (sub[SW - 1 - 8*l -: 8])
        );
    end

    if (SW == 128) begin : g_rot_full
        assign sr_rot = sub;
    end else begin : g_rot_part
        assign sr_rot = {sr[127-SW:0], sub};
    end

    assign last      = (cnt == CW'(N - 1));
    assign out_state = sr;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // in_ready is the only output allowed a combinational input path (from rst)
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready = ~rst;
            RUN:     busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr  <= in_state;
                    cnt <= '0;
                end
                RUN: begin
                    sr  <= sr_rot;
                    cnt <= last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq at 1, 4 and 16 lanes: latency, data,
// exhaustive inverse-table coverage, backpressure and mid-run reset.

module tb_inv_sub_bytes_seq;
    logic         clk;
    logic         rst;
    logic         out_ready;
    logic [127:0] in_state;
    logic [2:0]   iv;
    logic [2:0]   ir;
    logic [2:0]   ov;
    logic [2:0]   bz;
    logic [127:0] os [3];

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] KV_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] KV_OUT = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ALL63  = {16{8'h63}};

    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(in_state),
        .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0]), .busy(bz[0]));
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(in_state),
        .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1]), .busy(bz[1]));
    inv_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(in_state),
        .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2]), .busy(bz[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Forward S-box from GF(2^8) inverse plus affine map, independent of the RTL table
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    // Present s to instance idx, return at the negedge after the accept edge
    task automatic start(input int idx, input logic [127:0] s, input bit hold);
        int budget = 0;
        @(negedge clk);
        in_state = s;
        iv[idx]  = 1'b1;
        while (!ir[idx] && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("accept_timeout", 128'(ir[idx]), 128'(1));
        @(posedge clk);
        @(negedge clk);
        if (!hold) iv[idx] = 1'b0;
        check_eq("busy_after_accept", 128'(bz[idx]), 128'(1));
    endtask

    task automatic wait_out(input int idx, output int lat);
        lat = 0;
        while (!ov[idx] && lat < 64) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check_eq("out_valid_timeout", 128'(ov[idx]), 128'(1));
    endtask

    // With out_ready high, transfer on the next edge and return to IDLE
    task automatic finish_out(input int idx);
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid_drop", 128'(ov[idx]), 128'(0));
        check_eq("idle_ready", 128'(ir[idx]), 128'(1));
    endtask

    task automatic run_block(input int idx, input logic [127:0] s, input logic [127:0] exp,
                             input int exp_lat, input string tag);
        int lat;
        start(idx, s, 1'b0);
        wait_out(idx, lat);
        check_eq({tag, "_lat"}, 128'(lat), 128'(exp_lat));
        check_eq({tag, "_data"}, os[idx], exp);
        finish_out(idx);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [127:0] blk;
        logic [127:0] exp;

        rst       = 1'b1;
        out_ready = 1'b1;
        iv        = 3'b000;
        in_state  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 128'(ir), 128'(0));
        check_eq("rst_out_valid", 128'(ov), 128'(0));
        check_eq("rst_busy", 128'(bz), 128'(0));
        check_eq("rst_out_state", os[0], 128'(0));
        rst = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 128'(ir), 128'(3'b111));

        run_block(0, ALL63, 128'(0), 16, "all63_bpc1");
        run_block(0, KV_IN, KV_OUT, 16, "kv_bpc1");
        run_block(1, KV_IN, KV_OUT, 4, "kv_bpc4");
        run_block(2, KV_IN, KV_OUT, 1, "kv_bpc16");

        // Sixteen blocks covering sbox(0x00)..sbox(0xff) must invert to 0x00..0xff
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) begin
                blk[127 - 8*j -: 8] = fwd_sbox(8'(16*k + j));
                exp[127 - 8*j -: 8] = 8'(16*k + j);
            end
            run_block(0, blk, exp, 16, "table_bpc1");
            run_block(2, blk, exp, 1, "table_bpc16");
        end

        // Output held under backpressure while a new state waits on in_valid
        out_ready = 1'b0;
        start(0, KV_IN, 1'b0);
        wait_out(0, lat);
        check_eq("bp_lat", 128'(lat), 128'(16));
        check_eq("bp_data", os[0], KV_OUT);
        iv[0]    = 1'b1;
        in_state = ALL63;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_hold_valid", 128'(ov[0]), 128'(1));
            check_eq("bp_hold_data", os[0], KV_OUT);
            check_eq("bp_hold_ready", 128'(ir[0]), 128'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_release_valid", 128'(ov[0]), 128'(0));
        check_eq("bp_release_ready", 128'(ir[0]), 128'(1));
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        check_eq("bp_pending_busy", 128'(bz[0]), 128'(1));
        wait_out(0, lat);
        check_eq("bp_pending_lat", 128'(lat), 128'(16));
        check_eq("bp_pending_data", os[0], 128'(0));
        finish_out(0);

        // Reset in the seventh RUN cycle discards the block
        start(0, ALL63, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_out_valid", 128'(ov[0]), 128'(0));
        check_eq("midrst_busy", 128'(bz[0]), 128'(0));
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ov[0]) pulses++;
        end
        check_eq("midrst_no_pulse", 128'(pulses), 128'(0));
        run_block(0, KV_IN, KV_OUT, 16, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
